// File: rtl/qk_score.sv
// qk_score: SEQ_LEN-entry key cache plus scaled Q.K scoring (one MAC/cycle) with running max.
// Build macro QK_SCORE_SAT_EN: saturate each score to DATA_WIDTH instead of wrapping.
//   state | meaning
//   IDLE  | cache writable, waiting for start
//   CALC  | accumulate Q[j]*K_t[j] for entry t
//   WRITE | store score t, update max, advance t
//   DONE  | one-cycle completion pulse
module qk_score #(
    parameter int DATA_WIDTH  = 32,
    parameter int EMBED_DIM   = 64,
    parameter int FRAC_BITS   = 14,
    parameter int SEQ_LEN     = 8,
    parameter int SCALE_SHIFT = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            k_wr_en,
    input  logic [$clog2(SEQ_LEN)-1:0]      k_wr_idx,
    input  logic [DATA_WIDTH*EMBED_DIM-1:0] K_flat,
    input  logic                            k_clr,
    input  logic                            start,
    input  logic [DATA_WIDTH*EMBED_DIM-1:0] Q_flat,
    output logic                            busy,
    output logic                            done,
    output logic [SEQ_LEN-1:0]              valid_mask,
    output logic [DATA_WIDTH*SEQ_LEN-1:0]   scores_flat,
    output logic [DATA_WIDTH-1:0]           max_score,
    output logic [$clog2(SEQ_LEN)-1:0]      max_idx
);
    localparam int TW = $clog2(SEQ_LEN);
    localparam int JW = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
    localparam int AW = 2 * DATA_WIDTH;
    localparam logic [JW-1:0] J_LAST = JW'(EMBED_DIM - 1);
    localparam logic [TW-1:0] T_LAST = TW'(SEQ_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH*EMBED_DIM-1:0] cache [SEQ_LEN];
    logic [TW-1:0]                   t;
    logic [JW-1:0]                   j;
    logic signed [AW-1:0]            acc;
    logic [DATA_WIDTH-1:0]           q_elem, k_elem;
    logic signed [AW-1:0]            prod;
    logic [DATA_WIDTH-1:0]           s_red;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (j == J_LAST) state_nxt = WRITE;
            WRITE:   state_nxt = (t == T_LAST) ? DONE : CALC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign q_elem = Q_flat[int'(j)*DATA_WIDTH +: DATA_WIDTH];
    assign k_elem = cache[t][int'(j)*DATA_WIDTH +: DATA_WIDTH];
    assign prod   = $signed({{DATA_WIDTH{q_elem[DATA_WIDTH-1]}}, q_elem}) *
                    $signed({{DATA_WIDTH{k_elem[DATA_WIDTH-1]}}, k_elem});

`ifdef QK_SCORE_SAT_EN
    localparam logic signed [AW-1:0] S_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] S_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    logic signed [AW-1:0] s_full;
    assign s_full = acc >>> SCALE_SHIFT;
    assign s_red  = (s_full > S_MAX) ? MOST_POS :
                    (s_full < S_MIN) ? MOST_NEG : s_full[DATA_WIDTH-1:0];
`else
    logic unused_pos;
    assign unused_pos = ^MOST_POS;
    assign s_red = DATA_WIDTH'(acc >>> SCALE_SHIFT);
`endif

    // Cache data needs no reset; valid_mask gates every use of it.
    always_ff @(posedge clk) begin
        if (rst_n && state == IDLE && k_wr_en && !k_clr)
            cache[k_wr_idx] <= K_flat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t           <= '0;
            j           <= '0;
            acc         <= '0;
            valid_mask  <= '0;
            scores_flat <= '0;
            max_score   <= '0;
            max_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (k_clr)        valid_mask           <= '0;
                    else if (k_wr_en) valid_mask[k_wr_idx] <= 1'b1;
                    if (start) begin
                        t         <= '0;
                        j         <= '0;
                        acc       <= '0;
                        max_score <= MOST_NEG;
                        max_idx   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + (prod >>> FRAC_BITS);
                    if (j != J_LAST) j <= j + 1'b1;
                end
                WRITE: begin
                    if (valid_mask[t]) begin
                        scores_flat[int'(t)*DATA_WIDTH +: DATA_WIDTH] <= s_red;
                        // Strict compare: ties keep the lower index.
                        if ($signed(s_red) > $signed(max_score)) begin
                            max_score <= s_red;
                            max_idx   <= t;
                        end
                    end else begin
                        scores_flat[int'(t)*DATA_WIDTH +: DATA_WIDTH] <= MOST_NEG;
                    end
                    if (t != T_LAST) begin
                        t   <= t + 1'b1;
                        j   <= '0;
                        acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qk_score.sv
// Self-checking bench for qk_score: bench-side model feeds a scoreboard popped on each done pulse.
// Honours QK_SCORE_SAT_EN the same way as the design build.
module tb_qk_score;
    localparam int DW = 32;
    localparam int ED = 64;
    localparam int SL = 8;
    localparam int LAT = SL * (ED + 1) + 1;

    typedef struct packed {
        logic [DW*SL-1:0] scores;
        logic [DW-1:0]    max_s;
        logic [2:0]       max_i;
    } exp_t;

    logic             clk, rst_n, k_wr_en, k_clr, start;
    logic [2:0]       k_wr_idx;
    logic [DW*ED-1:0] K_flat, Q_flat;
    logic             busy, done;
    logic [SL-1:0]    valid_mask;
    logic [DW*SL-1:0] scores_flat;
    logic [DW-1:0]    max_score;
    logic [2:0]       max_idx;

    logic [DW-1:0] kmem [SL][ED];
    logic [DW-1:0] qv [ED];
    logic [SL-1:0] vmod;
    exp_t          sb [$];
    int            n_chk, n_fail;

    qk_score dut (
        .clk(clk), .rst_n(rst_n), .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx), .K_flat(K_flat),
        .k_clr(k_clr), .start(start), .Q_flat(Q_flat), .busy(busy), .done(done),
        .valid_mask(valid_mask), .scores_flat(scores_flat), .max_score(max_score), .max_idx(max_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model();
        exp_t e;
        logic signed [63:0] acc, p, s;
        logic [DW-1:0] r;
        e.scores = '0;
        e.max_s  = 32'h80000000;
        e.max_i  = 3'd0;
        for (int ti = 0; ti < SL; ti++) begin
            acc = 0;
            for (int ji = 0; ji < ED; ji++) begin
                p = $signed({{32{qv[ji][31]}}, qv[ji]}) * $signed({{32{kmem[ti][ji][31]}}, kmem[ti][ji]});
                acc = acc + (p >>> 14);
            end
            s = acc >>> 3;
`ifdef QK_SCORE_SAT_EN
            if (s > 64'sh000000007FFFFFFF)      r = 32'h7FFFFFFF;
            else if (s < -64'sh0000000080000000) r = 32'h80000000;
            else                                 r = s[31:0];
`else
            r = s[31:0];
`endif
            if (vmod[ti]) begin
                e.scores[ti*DW +: DW] = r;
                if ($signed(r) > $signed(e.max_s)) begin
                    e.max_s = r;
                    e.max_i = 3'(ti);
                end
            end else begin
                e.scores[ti*DW +: DW] = 32'h80000000;
            end
        end
        return e;
    endfunction

    task automatic load(input int idx);
        for (int ji = 0; ji < ED; ji++) K_flat[ji*DW +: DW] = kmem[idx][ji];
        k_wr_idx = 3'(idx);
        k_wr_en  = 1'b1;
        tick();
        k_wr_en  = 1'b0;
        vmod[idx] = 1'b1;
    endtask

    task automatic clear();
        k_clr = 1'b1;
        tick();
        k_clr = 1'b0;
        vmod  = '0;
    endtask

    task automatic set_q();
        for (int ji = 0; ji < ED; ji++) Q_flat[ji*DW +: DW] = qv[ji];
    endtask

    task automatic fill_k(input int idx, input logic [DW-1:0] v);
        for (int ji = 0; ji < ED; ji++) kmem[idx][ji] = v;
    endtask

    task automatic fill_q(input logic [DW-1:0] v);
        for (int ji = 0; ji < ED; ji++) qv[ji] = v;
    endtask

    // Drives one scoring run; inject pokes writes/start/clear while busy.
    task automatic run(input bit inject);
        exp_t e;
        int   cnt;
        set_q();
        sb.push_back(model());
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 1;
        check("busy_after_start", busy, 1);
        while (!done && cnt < 2000) begin
            k_wr_en = 1'b0; k_clr = 1'b0; start = 1'b0;
            if (inject) begin
                case (cnt)
                    30: begin k_wr_idx = 3'd3; K_flat = '0; k_wr_en = 1'b1; end
                    40: begin k_wr_idx = 3'd6; k_wr_en = 1'b1; end
                    50: start = 1'b1;
                    60: k_clr = 1'b1;
                    default: ;
                endcase
            end
            tick();
            cnt++;
        end
        k_wr_en = 1'b0; k_clr = 1'b0; start = 1'b0;
        check("latency", 64'(cnt), 64'(LAT));
        e = sb.pop_front();
        for (int ti = 0; ti < SL; ti++)
            check($sformatf("score%0d", ti), scores_flat[ti*DW +: DW], e.scores[ti*DW +: DW]);
        check("max_score", max_score, e.max_s);
        check("max_idx", max_idx, e.max_i);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int   cnt;
        bit   seen;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; k_wr_en = 1'b0; k_clr = 1'b0; start = 1'b0;
        k_wr_idx = '0; K_flat = '0; Q_flat = '0; vmod = '0;
        for (int ti = 0; ti < SL; ti++) fill_k(ti, 32'd0);
        fill_q(32'd0);
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", valid_mask, 0);
        check("rst_scores", scores_flat[63:0], 0);
        check("rst_max_score", max_score, 0);
        check("rst_max_idx", max_idx, 0);
        rst_n = 1'b1;
        tick();

        // Single valid entry, unit vectors
        fill_k(0, 32'd16384);
        load(0);
        check("valid_after_write", valid_mask, vmod);
        fill_q(32'd16384);
        run(1'b0);
        check("t1_score0", scores_flat[31:0], 32'd131072);
        check("t1_score1", scores_flat[63:32], 32'h80000000);
        check("t1_max", max_score, 32'd131072);
        check("t1_idx", max_idx, 0);

        // Tie between entries 2 and 5
        clear();
        fill_k(2, 32'd0); kmem[2][0] = 32'd32768; load(2);
        fill_k(5, 32'd0); kmem[5][0] = 32'd32768; load(5);
        fill_q(32'd0); qv[0] = 32'd16384;
        run(1'b0);
        check("t2_score2", scores_flat[2*DW +: DW], 32'd4096);
        check("t2_score5", scores_flat[5*DW +: DW], 32'd4096);
        check("t2_idx", max_idx, 2);

        // Negative score, with writes/start/clear poked while busy
        clear();
        fill_k(3, 32'hFFFFC000);
        load(3);
        fill_q(32'd16384);
        run(1'b1);
        check("t3_score3", scores_flat[3*DW +: DW], 32'hFFFE0000);
        check("t3_max", max_score, 32'hFFFE0000);
        check("t3_idx", max_idx, 3);
        check("t3_valid_held", valid_mask, 8'h08);

        // Clear beats write in the same cycle; then score with nothing valid
        k_clr = 1'b1; k_wr_en = 1'b1; k_wr_idx = 3'd4;
        tick();
        k_clr = 1'b0; k_wr_en = 1'b0; vmod = '0;
        check("clr_priority", valid_mask, 0);
        run(1'b0);
        check("none_max", max_score, 32'h80000000);
        check("none_idx", max_idx, 0);

        // Overflowing score: saturate or wrap
        fill_k(0, 32'h40000000);
        load(0);
        fill_q(32'h40000000);
        run(1'b0);
`ifdef QK_SCORE_SAT_EN
        check("sat_score0", scores_flat[31:0], 32'h7FFFFFFF);
`else
        check("wrap_score0", scores_flat[31:0], 32'h00000000);
`endif

        // Random small-magnitude vectors on a few entries
        clear();
        for (int ti = 0; ti < SL; ti++)
            for (int ji = 0; ji < ED; ji++)
                kmem[ti][ji] = 32'($signed($urandom_range(0, 131071)) - 65536);
        for (int ji = 0; ji < ED; ji++) qv[ji] = 32'($signed($urandom_range(0, 131071)) - 65536);
        load(1); load(4); load(7);
        run(1'b0);

        // Reset in the middle of an operation
        set_q();
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 1;
        while (cnt < 100) begin tick(); cnt++; end
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", valid_mask, 0);
        check("mid_rst_scores", scores_flat[127:0], 0);
        check("mid_rst_max", max_score, 0);
        check("mid_rst_idx", max_idx, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (600) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("no_done_after_rst", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
